// File: rtl/fc_engine.sv
// Fully-connected output layer: one time-shared multiplier/accumulator walks all
// classes over the captured pooled map, saturates each score and tracks the argmax.
//
// state | meaning
// IDLE  | waiting for en; outputs hold their last values
// INIT  | load accumulator with bias of class c, clear pixel counter
// MAC   | one multiply-accumulate per cycle over P pixels
// STORE | saturate score into fc_out[c], update argmax, next class or finish
// DONE  | results valid, done held until en falls
module fc_engine #(
  parameter int DATA_WIDTH       = 8,
  parameter int POOL_PIXEL_COUNT = 16,
  parameter int NUM_CLASSES      = 4,
  parameter int FC_BIAS_WIDTH    = 16,
  parameter int FC_MAC_WIDTH     = 24
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            en,
  input  logic        [DATA_WIDTH-1:0]    fc_in      [POOL_PIXEL_COUNT],
  input  logic signed [DATA_WIDTH-1:0]    fc_weights [NUM_CLASSES][POOL_PIXEL_COUNT],
  input  logic signed [FC_BIAS_WIDTH-1:0] fc_bias    [NUM_CLASSES],
  output logic signed [FC_MAC_WIDTH-1:0]  fc_out     [NUM_CLASSES],
  output logic [$clog2(NUM_CLASSES)-1:0]  class_idx,
  output logic                            busy,
  output logic                            done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] INIT  = 3'd1;
  localparam logic [2:0] MAC   = 3'd2;
  localparam logic [2:0] STORE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam int PW  = (POOL_PIXEL_COUNT > 1) ? $clog2(POOL_PIXEL_COUNT) : 1;
  localparam int CW  = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int PRW = 2*DATA_WIDTH + 1;
  // Accumulator is at least MAC+4 bits, widened when a narrow output width
  // would otherwise let bias plus P full-scale products wrap before saturation.
  localparam int NEED = ((FC_BIAS_WIDTH > PRW) ? FC_BIAS_WIDTH : PRW) + PW + 1;
  localparam int AW   = (FC_MAC_WIDTH + 4 > NEED) ? FC_MAC_WIDTH + 4 : NEED;

  localparam logic signed [AW-1:0] SAT_MAX =
    {{(AW-FC_MAC_WIDTH+1){1'b0}}, {(FC_MAC_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN =
    {{(AW-FC_MAC_WIDTH+1){1'b1}}, {(FC_MAC_WIDTH-1){1'b0}}};

  logic [2:0]                      state;
  logic [PW-1:0]                   p_cnt;
  logic [CW-1:0]                   c_cnt;
  logic signed [AW-1:0]            acc;
  logic signed [FC_MAC_WIDTH-1:0]  run_max;
  logic        [DATA_WIDTH-1:0]    in_r [POOL_PIXEL_COUNT];
  logic signed [DATA_WIDTH-1:0]    w_r  [NUM_CLASSES][POOL_PIXEL_COUNT];
  logic signed [FC_BIAS_WIDTH-1:0] b_r  [NUM_CLASSES];
  logic signed [PRW-1:0]           prod;
  logic signed [FC_MAC_WIDTH-1:0]  acc_sat;

  always_comb begin
    prod = PRW'($signed({1'b0, in_r[p_cnt]})) * PRW'(w_r[c_cnt][p_cnt]);
  end

  always_comb begin
    acc_sat = acc[FC_MAC_WIDTH-1:0];
    if (acc > SAT_MAX)
      acc_sat = SAT_MAX[FC_MAC_WIDTH-1:0];
    else if (acc < SAT_MIN)
      acc_sat = SAT_MIN[FC_MAC_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      p_cnt     <= '0;
      c_cnt     <= '0;
      acc       <= '0;
      run_max   <= '0;
      class_idx <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        fc_out[c] <= '0;
        b_r[c]    <= '0;
        for (int p = 0; p < POOL_PIXEL_COUNT; p++) w_r[c][p] <= '0;
      end
      for (int p = 0; p < POOL_PIXEL_COUNT; p++) in_r[p] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            in_r      <= fc_in;
            w_r       <= fc_weights;
            b_r       <= fc_bias;
            for (int c = 0; c < NUM_CLASSES; c++) fc_out[c] <= '0;
            class_idx <= '0;
            c_cnt     <= '0;
            busy      <= 1'b1;
            state     <= INIT;
          end
        end
        INIT, MAC, STORE: begin
          if (!en) begin
            // Abort keeps whatever was already stored, including class_idx.
            busy  <= 1'b0;
            state <= IDLE;
          end else if (state == INIT) begin
            acc   <= AW'(b_r[c_cnt]);
            p_cnt <= '0;
            state <= MAC;
          end else if (state == MAC) begin
            acc   <= acc + AW'(prod);
            p_cnt <= p_cnt + 1'b1;
            if (p_cnt == PW'(POOL_PIXEL_COUNT-1)) state <= STORE;
          end else begin
            fc_out[c_cnt] <= acc_sat;
            if (c_cnt == '0 || acc_sat > run_max) begin
              run_max   <= acc_sat;
              class_idx <= c_cnt;
            end
            if (c_cnt == CW'(NUM_CLASSES-1)) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              c_cnt <= c_cnt + 1'b1;
              state <= INIT;
            end
          end
        end
        DONE: begin
          if (!en) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
